// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller slice: the 2-bit ALU
// operation encodings and the default datapath/tag widths.
// Optional feature macro used by the slice: ALU_ISSUE_ZFLAG_EN (per-entry
// zero flag on the response port).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int WIDTH_DEF = 8;
    localparam int TAG_W_DEF = 2;

endpackage : alu_pkg

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Request and response handshake bundle of the ALU issue controller.
//   req_valid/req_ready/req_a/req_b/req_op/req_tag : operation request port
//   rsp_valid/rsp_ready/rsp_y/rsp_tag              : result response port
//   rsp_zero (ALU_ISSUE_ZFLAG_EN only)             : result-was-zero flag
// Modports:
//   master : the requester/consumer (drives requests, accepts responses)
//   slave  : the issue controller
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic             rsp_zero;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
`ifdef ALU_ISSUE_ZFLAG_EN
        input  rsp_zero,
`endif
        input  req_ready, rsp_valid, rsp_y, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
`ifdef ALU_ISSUE_ZFLAG_EN
        output rsp_zero,
`endif
        output req_ready, rsp_valid, rsp_y, rsp_tag
    );

endinterface : alu_issue_ctrl_if

// File: rtl/alu_issue_ctrl_chk.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_chk
// Protocol checker bound into the issue controller. The credit scheme makes
// a result arrive only when a FIFO slot is free and the response handshake
// only pops a non-empty FIFO; either violation means results are lost.
// Ports:
//   clk, rst : clock, async active-high reset (checks disabled in reset)
//   push_i   : result arriving from the final pipe stage
//   full_i   : response FIFO full
//   pop_i    : response handshake
//   empty_i  : response FIFO empty
// ---------------------------------------------------------------------------
module alu_issue_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic full_i,
    input logic pop_i,
    input logic empty_i
);

    a_no_push_on_full : assert property (@(posedge clk) disable iff (rst) !(push_i && full_i))
        else $error("alu_issue_ctrl: result pushed into a full response FIFO");

    a_no_pop_on_empty : assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_i))
        else $error("alu_issue_ctrl: pop from an empty response FIFO");

endmodule : alu_issue_ctrl_chk

// File: rtl/alu_rsp_fifo.sv
// ---------------------------------------------------------------------------
// alu_rsp_fifo
// Synchronous FIFO with asynchronous active-high reset holding ALU results.
// Head data is read straight from the storage register at the read pointer,
// so it is stable while no pop happens. Storage resets to zero so the head
// reads zero out of reset.
// Ports:
//   clk, rst      : clock, async active-high reset
//   push_i        : write push_data_i at the tail (caller guarantees !full)
//   push_data_i   : entry to write
//   pop_i         : drop the head entry (caller guarantees !empty)
//   head_data_o   : entry at the head
//   count_o       : number of stored entries ($clog2(DEPTH)+1 bits)
//   empty_o/full_o: occupancy flags
// ---------------------------------------------------------------------------
module alu_rsp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule : alu_rsp_fifo

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Requester side of a pipelined ALU. Requests are forwarded combinationally
// to the ALU; each issued op's tag travels down an ALU_LAT-deep valid/tag
// pipe so that when it reaches the last stage the ALU's Y is captured with
// that tag into the response FIFO. Issue is credit based: a request is only
// accepted while queued results plus in-flight ops leave a FIFO slot free,
// so results never need to be dropped.
// Ports:
//   clk, rst           : clock, async active-high reset
//   bus (slave)        : request / response handshakes (alu_issue_ctrl_if)
//   alu_a_o/alu_b_o    : ALU operands, copies of req_a/req_b
//   alu_op_o           : ALU operation, copy of req_op
//   alu_y_i            : ALU result, valid ALU_LAT cycles after the sample edge
// Macro ALU_ISSUE_ZFLAG_EN adds bus.rsp_zero, a stored per-entry Y==0 flag.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [1:0]        alu_op_o,
    input  logic [WIDTH-1:0]  alu_y_i
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    // Wide enough for fifo_count + every pipe stage valid at once.
    localparam int CRED_W = $clog2(FIFO_DEPTH + ALU_LAT + 1) + 1;
`ifdef ALU_ISSUE_ZFLAG_EN
    localparam int DATA_W = WIDTH + TAG_W + 1;
`else
    localparam int DATA_W = WIDTH + TAG_W;
`endif

    logic [ALU_LAT-1:0] pipe_vld_q;
    logic [TAG_W-1:0]   pipe_tag_q [ALU_LAT];

    logic               issue_s;
    logic               req_ready_s;
    logic [CRED_W-1:0]  pipe_cnt_s;
    logic [CRED_W-1:0]  credit_used_s;

    logic               fifo_push_s;
    logic               fifo_pop_s;
    logic [DATA_W-1:0]  fifo_push_data_s;
    logic [DATA_W-1:0]  fifo_head_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;

    // ALU operands are a straight copy of the request; the ALU samples them on the issue edge.
    assign alu_a_o  = bus.req_a;
    assign alu_b_o  = bus.req_b;
    assign alu_op_o = bus.req_op;

    // Count ops still travelling through the ALU; they each own a FIFO slot already.
    always_comb begin
        pipe_cnt_s = {CRED_W{1'b0}};
        for (int i = 0; i < ALU_LAT; i++) begin
            pipe_cnt_s = pipe_cnt_s + CRED_W'(pipe_vld_q[i]);
        end
    end

    // Credit check uses only registered state, so rsp_ready never reaches req_ready.
    assign credit_used_s = CRED_W'(fifo_count_s) + pipe_cnt_s;
    assign req_ready_s   = (credit_used_s < CRED_W'(FIFO_DEPTH));
    assign issue_s       = bus.req_valid & req_ready_s;
    assign bus.req_ready = req_ready_s;

    // Valid/tag shift pipe that tracks each issued op through the ALU latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= {ALU_LAT{1'b0}};
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe_tag_q[i] <= {TAG_W{1'b0}};
            end
        end else begin
            pipe_vld_q[0] <= issue_s;
            pipe_tag_q[0] <= issue_s ? bus.req_tag : {TAG_W{1'b0}};
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    // Final stage valid means alu_y_i belongs to that stage's tag this cycle.
    assign fifo_push_s = pipe_vld_q[ALU_LAT-1];
`ifdef ALU_ISSUE_ZFLAG_EN
    assign fifo_push_data_s = {(alu_y_i == {WIDTH{1'b0}}), alu_y_i, pipe_tag_q[ALU_LAT-1]};
`else
    assign fifo_push_data_s = {alu_y_i, pipe_tag_q[ALU_LAT-1]};
`endif

    assign fifo_pop_s = ~fifo_empty_s & bus.rsp_ready;

    alu_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push_s),
        .push_data_i (fifo_push_data_s),
        .pop_i       (fifo_pop_s),
        .head_data_o (fifo_head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

    alu_issue_ctrl_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_s),
        .full_i  (fifo_full_s),
        .pop_i   (fifo_pop_s),
        .empty_i (fifo_empty_s)
    );

    // Response port is the FIFO head; it only changes on a pop or when the FIFO fills from empty.
    assign bus.rsp_valid = ~fifo_empty_s;
    assign bus.rsp_tag   = fifo_head_s[TAG_W-1:0];
    assign bus.rsp_y     = fifo_head_s[TAG_W +: WIDTH];
`ifdef ALU_ISSUE_ZFLAG_EN
    assign bus.rsp_zero  = fifo_head_s[DATA_W-1];
`endif

endmodule : alu_issue_ctrl
